// File: rtl/kbd_event_wb_initiator_pkg.sv
// rtl/kbd_event_wb_initiator_pkg.sv - shared widths, event record and FSM encoding for the keyboard WB initiator
package kbd_event_wb_initiator_pkg;

    localparam int WB_ADDR_WIDTH  = 16;
    localparam int DATA_WIDTH     = 8;
    localparam int KBD_ROW_COUNT  = 10;
    localparam int KBD_ADDR_WIDTH = 4;
    localparam int KBD_COL_WIDTH  = 3;

    typedef struct packed {
        logic [KBD_ADDR_WIDTH-1:0] row;
        logic [KBD_COL_WIDTH-1:0]  col;
        logic                      pressed;
    } kbd_event_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_REQ   = 3'd3,
        ST_WR_WAIT  = 3'd4,
        ST_CLR_REQ  = 3'd5,
        ST_CLR_WAIT = 3'd6
    } kbd_init_state_t;

    // Matrix rows are active-low: a pressed key clears its bit.
    function automatic logic [DATA_WIDTH-1:0] apply_event(
        input logic [DATA_WIDTH-1:0]    d,
        input logic [KBD_COL_WIDTH-1:0] col,
        input logic                     pressed
    );
        logic [DATA_WIDTH-1:0] mask;
        mask = DATA_WIDTH'(1) << col;
        return pressed ? (d & ~mask) : (d | mask);
    endfunction

endpackage

// File: rtl/kbd_event_wb_initiator_fifo.sv
// rtl/kbd_event_wb_initiator_fifo.sv - show-ahead synchronous FIFO holding queued key events
// Ports: i_clk/i_rst (async active-high), i_push/i_data, i_pop/o_data (valid while !o_empty),
//        o_full/o_empty registered status flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_next;

    // A push while full is only legal when the same cycle pops.
    assign w_do_push = i_push && (!r_full || i_pop);
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (AW+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/kbd_event_wb_initiator.sv
// rtl/kbd_event_wb_initiator.sv - WB B4 pipelined initiator applying key events as row read-modify-writes
// Ports: wb_clock_i/wb_reset_i; evt_valid_i/evt_ready_o with evt_row_i/evt_col_i/evt_pressed_i;
//        clear_i pulse; busy_o, sticky err_o; WB master wb_addr_o/wb_data_o/wb_we_o/wb_cycle_o/
//        wb_strobe_o with wb_data_i/wb_stall_i/wb_ack_i.
module kbd_event_wb_initiator
    import kbd_event_wb_initiator_pkg::*;
#(
    parameter logic [WB_ADDR_WIDTH-1:0] KBD_WB_BASE = '0,
    parameter int                       FIFO_DEPTH  = 8,
    parameter int                       ACK_TIMEOUT = 15
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_i,
    input  logic                      evt_valid_i,
    output logic                      evt_ready_o,
    input  logic [KBD_ADDR_WIDTH-1:0] evt_row_i,
    input  logic [KBD_COL_WIDTH-1:0]  evt_col_i,
    input  logic                      evt_pressed_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [WB_ADDR_WIDTH-1:0]  wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic                      wb_we_o,
    output logic                      wb_cycle_o,
    output logic                      wb_strobe_o,
    input  logic                      wb_stall_i,
    input  logic                      wb_ack_i
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]             TMO_LOAD = TW'(ACK_TIMEOUT);
    localparam logic [KBD_ADDR_WIDTH-1:0] LAST_ROW = KBD_ADDR_WIDTH'(KBD_ROW_COUNT - 1);

    kbd_init_state_t           r_state;
    logic [TW-1:0]             r_timer;
    logic [KBD_ADDR_WIDTH-1:0] r_row_idx;
    logic [KBD_COL_WIDTH-1:0]  r_col;
    logic                      r_pressed;
    logic                      r_clear_pending;
    logic                      r_err;
    logic                      r_cyc;
    logic                      r_stb;
    logic                      r_we;
    logic [WB_ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;

    kbd_event_t                w_push_evt;
    kbd_event_t                w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_in_clr;
    logic                      w_clear_req;
    logic                      w_req_state;
    logic                      w_wait_state;
    logic                      w_expired;
    logic [KBD_ADDR_WIDTH-1:0] w_next_row;

    assign w_push_evt   = {evt_row_i, evt_col_i, evt_pressed_i};
    assign w_push       = evt_valid_i && evt_ready_o;
    assign w_in_clr     = (r_state == ST_CLR_REQ) || (r_state == ST_CLR_WAIT);
    // A clear arriving in the same cycle as IDLE is honoured immediately so it beats any queued event.
    assign w_clear_req  = r_clear_pending || clear_i;
    assign w_pop        = (r_state == ST_IDLE) && !w_clear_req && !w_empty;
    assign w_req_state  = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ) || (r_state == ST_CLR_REQ);
    assign w_wait_state = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT) || (r_state == ST_CLR_WAIT);
    assign w_expired    = (r_timer == '0);
    assign w_next_row   = r_row_idx + KBD_ADDR_WIDTH'(1);

    sync_fifo #(
        .WIDTH ($bits(kbd_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clock_i),
        .i_rst   (wb_reset_i),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_row_idx       <= '0;
            r_col           <= '0;
            r_pressed       <= 1'b0;
            r_clear_pending <= 1'b0;
            r_err           <= 1'b0;
            r_cyc           <= 1'b0;
            r_stb           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
        end else begin
            if (clear_i && !w_in_clr) begin
                r_clear_pending <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_clear_req) begin
                        r_clear_pending <= 1'b1;
                        r_row_idx       <= '0;
                        r_addr          <= KBD_WB_BASE;
                        r_wdata         <= '1;
                        r_we            <= 1'b1;
                        r_cyc           <= 1'b1;
                        r_stb           <= 1'b1;
                        r_timer         <= TMO_LOAD;
                        r_state         <= ST_CLR_REQ;
                    end else if (!w_empty) begin
                        if (w_head.row >= KBD_ADDR_WIDTH'(KBD_ROW_COUNT)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_col     <= w_head.col;
                            r_pressed <= w_head.pressed;
                            r_addr    <= KBD_WB_BASE | WB_ADDR_WIDTH'(w_head.row);
                            r_we      <= 1'b0;
                            r_cyc     <= 1'b1;
                            r_stb     <= 1'b1;
                            r_timer   <= TMO_LOAD;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ, ST_WR_REQ, ST_CLR_REQ: begin
                    if (!wb_stall_i) begin
                        r_stb <= 1'b0;
                        r_state <= (r_state == ST_RD_REQ) ? ST_RD_WAIT :
                                   (r_state == ST_WR_REQ) ? ST_WR_WAIT : ST_CLR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (wb_ack_i) begin
                        r_wdata <= apply_event(wb_data_i, r_col, r_pressed);
                        r_we    <= 1'b1;
                        r_stb   <= 1'b1;
                        r_timer <= TMO_LOAD;
                        r_state <= ST_WR_REQ;
                    end
                end
                ST_WR_WAIT: begin
                    if (wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLR_WAIT: begin
                    if (wb_ack_i) begin
                        if (r_row_idx == LAST_ROW) begin
                            r_cyc           <= 1'b0;
                            r_we            <= 1'b0;
                            r_clear_pending <= 1'b0;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_row_idx <= w_next_row;
                            r_addr    <= KBD_WB_BASE | WB_ADDR_WIDTH'(w_next_row);
                            r_stb     <= 1'b1;
                            r_timer   <= TMO_LOAD;
                            r_state   <= ST_CLR_REQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Watchdog: one budget per request, covering both stall and ack wait.
            if ((w_req_state && wb_stall_i) || (w_wait_state && !wb_ack_i)) begin
                if (w_expired) begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                    if (w_in_clr) begin
                        r_clear_pending <= 1'b0;
                    end
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
            end
        end
    end

    assign evt_ready_o = !w_full && !wb_reset_i;
    assign busy_o      = (r_state != ST_IDLE) || !w_empty || r_clear_pending;
    assign err_o       = r_err;
    assign wb_addr_o   = r_addr;
    assign wb_data_o   = r_wdata;
    assign wb_we_o     = r_we;
    assign wb_cycle_o  = r_cyc;
    assign wb_strobe_o = r_stb;

endmodule

// File: tb/tb_kbd_event_wb_initiator.sv
// tb/tb_kbd_event_wb_initiator.sv - self-checking bench with matrix peripheral model and stall/ack injector
module tb_kbd_event_wb_initiator;
    import kbd_event_wb_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [3:0]  evt_row = '0;
    logic [2:0]  evt_col = '0;
    logic        evt_pressed = 1'b0;
    logic        clear = 1'b0;
    logic        busy, err;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata = '0;
    logic        we, cyc, stb;
    logic        stall = 1'b0;
    logic        ack_r = 1'b0;
    logic        no_ack = 1'b0;

    logic        pl_en = 1'b0;
    logic [3:0]  pl_row = '0;
    logic [7:0]  pl_val = '0;
    logic [7:0]  mem [16];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } wb_rec_t;
    wb_rec_t log_q[$];
    int      cyc_rises = 0;
    logic    cyc_d = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    kbd_event_wb_initiator #(
        .KBD_WB_BASE (16'h0000),
        .FIFO_DEPTH  (8),
        .ACK_TIMEOUT (15)
    ) dut (
        .wb_clock_i    (clk),
        .wb_reset_i    (rst),
        .evt_valid_i   (evt_valid),
        .evt_ready_o   (evt_ready),
        .evt_row_i     (evt_row),
        .evt_col_i     (evt_col),
        .evt_pressed_i (evt_pressed),
        .clear_i       (clear),
        .busy_o        (busy),
        .err_o         (err),
        .wb_addr_o     (addr),
        .wb_data_o     (wdata),
        .wb_data_i     (rdata),
        .wb_we_o       (we),
        .wb_cycle_o    (cyc),
        .wb_strobe_o   (stb),
        .wb_stall_i    (stall),
        .wb_ack_i      (ack_r)
    );

    // Matrix peripheral: pipelined slave, ack one cycle after an accepted strobe.
    always @(posedge clk) begin
        ack_r <= cyc && stb && !stall && !no_ack;
        rdata <= mem[addr[3:0]];
        cyc_d <= cyc;
        if (cyc && !cyc_d) cyc_rises <= cyc_rises + 1;
        if (cyc && stb && !stall) begin
            log_q.push_back({we, addr, wdata});
            if (we) mem[addr[3:0]] <= wdata;
        end
        if (pl_en) mem[pl_row] <= pl_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic preload(input logic [3:0] r, input logic [7:0] v);
        pl_row = r;
        pl_val = v;
        pl_en  = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic push_evt(input logic [3:0] r, input logic [2:0] c, input logic p,
                            output logic first_ready);
        evt_row = r;
        evt_col = c;
        evt_pressed = p;
        evt_valid = 1'b1;
        @(negedge clk);
        first_ready = evt_ready;
        for (int i = 0; i < 300 && !evt_ready; i++) @(negedge clk);
        if (!evt_ready) chk("push_timeout", 32'(evt_ready), 32'd1);
        @(posedge clk);
        #1 evt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] row;
        logic [2:0] col;
        logic       pressed;
        logic [7:0] init;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   base, rises0, n, rdy_cnt;
        logic fr;

        vecs[0] = '{4'd3, 3'd5, 1'b1, 8'hFF, 8'hDF};
        vecs[1] = '{4'd3, 3'd5, 1'b0, 8'hDF, 8'hFF};
        vecs[2] = '{4'd3, 3'd5, 1'b0, 8'hFF, 8'hFF};
        vecs[3] = '{4'd0, 3'd0, 1'b1, 8'hFF, 8'hFE};
        vecs[4] = '{4'd9, 3'd7, 1'b1, 8'h0F, 8'h0F};
        vecs[5] = '{4'd9, 3'd7, 1'b0, 8'h0F, 8'h8F};
        vecs[6] = '{4'd5, 3'd2, 1'b1, 8'h55, 8'h51};

        do_reset();
        @(negedge clk);
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(evt_ready), 1);

        // Table-driven single events.
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].row, vecs[i].init);
            base = log_q.size();
            push_evt(vecs[i].row, vecs[i].col, vecs[i].pressed, fr);
            if (i == 0) begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1 n++;
                end while (cyc && n < 50);
                chk("latency", 32'(n), 32'd5);
            end
            wait_idle(100);
            chk("vec_nreq", 32'(log_q.size() - base), 32'd2);
            if (log_q.size() >= base + 2) begin
                chk("vec_read", {15'd0, log_q[base].we, log_q[base].addr}, {16'd0, 12'd0, vecs[i].row});
                chk("vec_write", {log_q[base+1].we, log_q[base+1].addr, log_q[base+1].data},
                    {1'b1, 12'd0, vecs[i].row, vecs[i].exp});
            end
            chk("vec_mem", 32'(mem[vecs[i].row]), 32'(vecs[i].exp));
        end
        chk("vec_err", 32'(err), 0);

        // Clear-all under one cycle.
        for (int r = 0; r < 10; r++) preload(4'(r), 8'h00);
        base = log_q.size();
        rises0 = cyc_rises;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        wait_idle(200);
        chk("clr_nreq", 32'(log_q.size() - base), 32'd10);
        n = 0;
        for (int r = 0; r < 10; r++) begin
            if (log_q.size() > base + r && log_q[base+r] == {1'b1, 16'(r), 8'hFF} && mem[r] == 8'hFF) n++;
        end
        chk("clr_rows", 32'(n), 32'd10);
        chk("clr_one_cyc", 32'(cyc_rises - rises0), 32'd1);
        chk("clr_busy", 32'(busy), 0);

        // Clear coincident with an event push: clear runs first.
        base = log_q.size();
        rises0 = cyc_rises;
        evt_row = 4'd4; evt_col = 3'd3; evt_pressed = 1'b1;
        evt_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
        clear = 1'b0;
        wait_idle(300);
        chk("race_nreq", 32'(log_q.size() - base), 32'd12);
        if (log_q.size() >= base + 12) begin
            chk("race_clr_first", {log_q[base].we, log_q[base].addr, log_q[base].data}, {1'b1, 16'h0, 8'hFF});
            chk("race_clr_last", {log_q[base+9].we, log_q[base+9].addr, log_q[base+9].data}, {1'b1, 16'h9, 8'hFF});
            chk("race_evt_rd", {log_q[base+10].we, log_q[base+10].addr}, {1'b0, 16'h4});
            chk("race_evt_wr", {log_q[base+11].we, log_q[base+11].addr, log_q[base+11].data}, {1'b1, 16'h4, 8'hF7});
        end
        chk("race_cycs", 32'(cyc_rises - rises0), 32'd2);

        // Backpressure: nine events queued behind a stalled clear.
        base = log_q.size();
        rdy_cnt = 0;
        stall = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        fork
            begin
                repeat (12) @(posedge clk);
                #1 stall = 1'b0;
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    push_evt(4'(k), 3'(k), 1'b1, fr);
                    if (k < 8 && fr) rdy_cnt++;
                    if (k == 8) chk("bp_ready_9th", 32'(fr), 0);
                end
            end
        join
        chk("bp_ready_first8", 32'(rdy_cnt), 32'd8);
        wait_idle(600);
        chk("bp_nreq", 32'(log_q.size() - base), 32'd28);
        for (int k = 0; k < 9; k++) begin
            if (log_q.size() >= base + 12 + 2*k)
                chk("bp_order", {log_q[base+11+2*k].we, log_q[base+11+2*k].addr, log_q[base+11+2*k].data},
                    {1'b1, 16'(k), 8'hFF & ~(8'd1 << (k % 8))});
        end
        chk("bp_err", 32'(err), 0);

        // Out-of-range row: dropped, no bus traffic.
        base = log_q.size();
        push_evt(4'd12, 3'd0, 1'b1, fr);
        wait_idle(50);
        chk("row12_nreq", 32'(log_q.size() - base), 0);
        chk("row12_err", 32'(err), 1);

        // Missing ack: abort, then next event proceeds.
        do_reset();
        preload(4'd2, 8'hFF);
        no_ack = 1'b1;
        push_evt(4'd2, 3'd1, 1'b1, fr);
        n = 0;
        while (!cyc && n < 10) begin @(posedge clk); #1 n++; end
        n = 0;
        while (cyc && n < 40) begin @(posedge clk); #1 n++; end
        chk("tmo_cyc", 32'(cyc), 0);
        chk("tmo_window", 32'(n >= 15 && n <= 20), 1);
        chk("tmo_err", 32'(err), 1);
        no_ack = 1'b0;
        base = log_q.size();
        push_evt(4'd2, 3'd1, 1'b1, fr);
        wait_idle(100);
        chk("tmo_next_nreq", 32'(log_q.size() - base), 32'd2);
        chk("tmo_next_mem", 32'(mem[2]), 32'hFD);

        // Reset while waiting for a read ack.
        do_reset();
        no_ack = 1'b1;
        push_evt(4'd1, 3'd0, 1'b1, fr);
        push_evt(4'd1, 3'd1, 1'b1, fr);
        n = 0;
        while (!(cyc && !stb) && n < 20) begin @(negedge clk); n++; end
        chk("rdwait_reached", 32'(cyc && !stb), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_cyc", 32'(cyc), 0);
        chk("rstmid_stb", 32'(stb), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        no_ack = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_ready", 32'(evt_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
